csa3_operand_collector: RTL and testbench



---
 rtl/csa_pkg.sv | 14 +
 rtl/csa3_operand_collector_csa.sv | 24 ++
 rtl/csa3_operand_collector.sv | 100 ++++++++++
 tb/tb_csa3_operand_collector.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the 3-operand carry-save adder and its operand collector.
package csa_pkg;

    localparam int CSA_OPW  = 4;
    localparam int CSA_SUMW = 6;

    typedef enum logic [1:0] {
        GET0   = 2'd0,
        GET1   = 2'd1,
        GET2   = 2'd2,
        RESULT = 2'd3
    } csa_col_state_t;

endpackage

// File: rtl/csa3_operand_collector_csa.sv
// Combinational 3-operand, 4-bit carry-save adder: one 3:2 compression layer
// followed by a final carry-propagate add of the sum and shifted carry vectors.
module CSA
    import csa_pkg::*;
(
    input  logic [CSA_OPW-1:0] x,
    input  logic [CSA_OPW-1:0] y,
    input  logic [CSA_OPW-1:0] z,
    output logic [CSA_OPW:0]   s,
    output logic               cout
);

    logic [CSA_OPW-1:0]  partial_sum;
    logic [CSA_OPW-1:0]  partial_carry;
    logic [CSA_SUMW-1:0] total;

    assign partial_sum   = x ^ y ^ z;
    assign partial_carry = (x & y) | (x & z) | (y & z);
    assign total         = {2'b00, partial_sum} + {1'b0, partial_carry, 1'b0};

    assign s    = total[CSA_OPW:0];
    assign cout = total[CSA_SUMW-1];

endmodule

// File: rtl/csa3_operand_collector.sv
// Valid/ready front-end that gathers operands into zero-padded triples,
// feeds them to the CSA and holds the result until downstream takes it.
module csa3_operand_collector
    import csa_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CSA_OPW-1:0]  in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CSA_SUMW-1:0] out_sum,
    output logic [1:0]          out_count
);

    csa_col_state_t     state;
    logic [CSA_OPW-1:0] x_r;
    logic [CSA_OPW-1:0] y_r;
    logic [CSA_OPW-1:0] z_r;
    logic [1:0]         count_r;
    logic [CSA_OPW:0]   csa_s;
    logic               csa_cout;
    logic               in_xfer;
    logic               out_xfer;

    assign in_ready  = (state != RESULT);
    assign out_valid = (state == RESULT);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    CSA u_csa (
        .x    (x_r),
        .y    (y_r),
        .z    (z_r),
        .s    (csa_s),
        .cout (csa_cout)
    );

    // Results are masked outside RESULT so idle outputs read as zero.
    assign out_sum   = out_valid ? {csa_cout, csa_s} : '0;
    assign out_count = out_valid ? count_r : 2'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= GET0;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            count_r <= 2'd0;
        end else begin
            case (state)
                GET0: begin
                    if (in_xfer) begin
                        x_r <= in_data;
                        if (in_last) begin
                            y_r     <= '0;
                            z_r     <= '0;
                            count_r <= 2'd1;
                            state   <= RESULT;
                        end else begin
                            state <= GET1;
                        end
                    end
                end
                GET1: begin
                    if (in_xfer) begin
                        y_r <= in_data;
                        if (in_last) begin
                            z_r     <= '0;
                            count_r <= 2'd2;
                            state   <= RESULT;
                        end else begin
                            state <= GET2;
                        end
                    end
                end
                GET2: begin
                    if (in_xfer) begin
                        z_r     <= in_data;
                        count_r <= 2'd3;
                        state   <= RESULT;
                    end
                end
                RESULT: begin
                    if (out_xfer) begin
                        x_r     <= '0;
                        y_r     <= '0;
                        z_r     <= '0;
                        count_r <= 2'd0;
                        state   <= GET0;
                    end
                end
                default: state <= GET0;
            endcase
        end
    end

endmodule

// File: tb/tb_csa3_operand_collector.sv
// Directed self-checking bench for csa3_operand_collector.
module tb_csa3_operand_collector;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_sum;
    logic [1:0] out_count;

    int tests_run = 0;
    int tests_failed = 0;

    csa3_operand_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic send(input logic [3:0] data, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        check("reset_in_ready",  {7'd0, in_ready},  8'd1);
        check("reset_out_valid", {7'd0, out_valid}, 8'd0);
        check("reset_out_sum",   {2'd0, out_sum},   8'd0);
        check("reset_out_count", {6'd0, out_count}, 8'd0);
        rst_n = 1'b1;
        tick();

        // Triple 5,6,7 with out_ready held high
        send(4'd5, 1'b0);
        send(4'd6, 1'b0);
        check("t567_not_valid_early", {7'd0, out_valid}, 8'd0);
        send(4'd7, 1'b0);
        check("t567_valid", {7'd0, out_valid}, 8'd1);
        check("t567_sum",   {2'd0, out_sum},   8'd18);
        check("t567_count", {6'd0, out_count}, 8'd3);
        check("t567_in_ready_low", {7'd0, in_ready}, 8'd0);
        tick();
        check("t567_valid_one_cycle", {7'd0, out_valid}, 8'd0);
        check("t567_idle_sum",  {2'd0, out_sum},  8'd0);
        check("t567_in_ready_back", {7'd0, in_ready}, 8'd1);

        // Maximum triple
        send(4'd15, 1'b0);
        send(4'd15, 1'b0);
        send(4'd15, 1'b0);
        check("t15_sum",   {2'd0, out_sum},   8'd45);
        check("t15_cout",  {7'd0, out_sum[5]}, 8'd1);
        check("t15_count", {6'd0, out_count}, 8'd3);
        tick();

        // Single operand closed by in_last
        send(4'd9, 1'b1);
        check("s9_valid", {7'd0, out_valid}, 8'd1);
        check("s9_sum",   {2'd0, out_sum},   8'd9);
        check("s9_count", {6'd0, out_count}, 8'd1);
        tick();

        // Pair closed by in_last on the second operand
        send(4'd12, 1'b0);
        send(4'd3, 1'b1);
        check("p12_3_valid", {7'd0, out_valid}, 8'd1);
        check("p12_3_sum",   {2'd0, out_sum},   8'd15);
        check("p12_3_count", {6'd0, out_count}, 8'd2);
        tick();

        // Backpressure with an operand continuously offered during RESULT
        out_ready = 1'b0;
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'd4;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    {7'd0, out_valid}, 8'd1);
            check("bp_sum",      {2'd0, out_sum},   8'd6);
            check("bp_count",    {6'd0, out_count}, 8'd3);
            check("bp_in_ready", {7'd0, in_ready},  8'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_consumed_valid", {7'd0, out_valid}, 8'd0);
        check("bp_get0_in_ready",  {7'd0, in_ready},  8'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_held_op_valid", {7'd0, out_valid}, 8'd1);
        check("bp_held_op_sum",   {2'd0, out_sum},   8'd4);
        check("bp_held_op_count", {6'd0, out_count}, 8'd1);
        tick();

        // Reset in the middle of a group discards the partial operands
        send(4'd7, 1'b0);
        send(4'd8, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_valid",    {7'd0, out_valid}, 8'd0);
        check("rst_mid_in_ready", {7'd0, in_ready},  8'd1);
        send(4'd1, 1'b0);
        send(4'd1, 1'b0);
        check("rst_mid_not_early", {7'd0, out_valid}, 8'd0);
        send(4'd1, 1'b0);
        check("rst_mid_sum_valid", {7'd0, out_valid}, 8'd1);
        check("rst_mid_sum",       {2'd0, out_sum},   8'd3);
        check("rst_mid_count",     {6'd0, out_count}, 8'd3);
        tick();
        check("final_idle", {7'd0, out_valid}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
